// File: rtl/cpu54_pkg.sv
// Shared constants and the hex-to-seven-segment decoder for the CPU54 board top.
package cpu54_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int DATA_W     = NUM_DIGITS * NIBBLE_W;

    // Display drive is active-low: a 0 lights a segment or selects a digit.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

    typedef logic [NUM_DIGITS-1:0] digit_sel_t;
    typedef logic [7:0]            seg_pat_t;

    localparam digit_sel_t CS_RESET   = 8'hFE;
    localparam seg_pat_t   ATOG_RESET = 8'h03;

    // Returns {a,b,c,d,e,f,g,dp}; the decimal point is never lit.
    function automatic seg_pat_t hexseg(input logic [NIBBLE_W-1:0] nib);
        logic [6:0] ag;
        case (nib)
            4'h0: ag = 7'b0000001;
            4'h1: ag = 7'b1001111;
            4'h2: ag = 7'b0010010;
            4'h3: ag = 7'b0000110;
            4'h4: ag = 7'b1001100;
            4'h5: ag = 7'b0100100;
            4'h6: ag = 7'b0100000;
            4'h7: ag = 7'b0001111;
            4'h8: ag = 7'b0000000;
            4'h9: ag = 7'b0000100;
            4'hA: ag = 7'b0001000;
            4'hB: ag = 7'b1100000;
            4'hC: ag = 7'b0110001;
            4'hD: ag = 7'b1000010;
            4'hE: ag = 7'b0110000;
            default: ag = 7'b0111000;
        endcase
        return {ag, SEG_OFF};
    endfunction

endpackage

// File: rtl/cpu54_disp_if.sv
// Display publish bus between the CPU54 core (master) and the display logic (slave).
interface cpu54_disp_if;
    import cpu54_pkg::*;

    logic              disp_we;
    logic [DATA_W-1:0] disp_data;

    modport master (output disp_we, output disp_data);
    modport slave  (input  disp_we, input  disp_data);
endinterface

// File: rtl/cpu54_core.sv
// Stand-in for the CPU54 pipeline core: publishes a slowly incrementing count so the
// board shows activity. Same ports as the real core, so either drops in.
module cpu54_core
    import cpu54_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    cpu54_disp_if.master disp
);
    logic [23:0]       tick_q  = '0;
    logic [23:0]       tick_d;
    logic [DATA_W-1:0] count_q = '0;
    logic [DATA_W-1:0] count_d;
    logic              pub_q   = 1'b0;
    logic              pub_d;

    always_comb begin
        tick_d  = tick_q + 1'b1;
        pub_d   = &tick_q;
        count_d = pub_d ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= '0;
            count_q <= '0;
            pub_q   <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            count_q <= count_d;
            pub_q   <= pub_d;
        end
    end

    assign disp.disp_we   = pub_q;
    assign disp.disp_data = count_q;
endmodule

// File: rtl/seg7_scan.sv
// Multiplexed eight-digit scanner: prescaler, digit index and a registered
// segment/select output so every digit change lands cleanly on a clock edge.
module seg7_scan
    import cpu54_pkg::*;
#(
    parameter int DIV_BITS = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    output seg_pat_t          atog,
    output digit_sel_t        seg_cs
);
    // NOTE: declaration initialisers give the FPGA bitstream its power-up state, which
    // equals the reset state, so the scan is valid even if reset never asserts.
    logic [DIV_BITS-1:0] presc_q  = '0;
    logic [DIV_BITS-1:0] presc_d;
    logic [2:0]          idx_q    = '0;
    logic [2:0]          idx_d;
    seg_pat_t            atog_q   = ATOG_RESET;
    seg_pat_t            atog_d;
    digit_sel_t          seg_cs_q = CS_RESET;
    digit_sel_t          seg_cs_d;
    logic [NIBBLE_W-1:0] nibble;

    // NOTE: every signal gets its value at the top of always_comb so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        if (&presc_q) begin
            idx_d = idx_q + 1'b1;
        end
        nibble   = value[{idx_q, 2'b00} +: NIBBLE_W];
        seg_cs_d = ~(digit_sel_t'(1) << idx_q);
        atog_d   = hexseg(nibble);
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            atog_q   <= ATOG_RESET;
            seg_cs_q <= CS_RESET;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            atog_q   <= atog_d;
            seg_cs_q <= seg_cs_d;
        end
    end

    assign atog   = atog_q;
    assign seg_cs = seg_cs_q;
endmodule

// File: rtl/top_display_wrapper.sv
// Board top: CPU54 core publishes a 32-bit value that is latched and shown as eight hex
// digits. USE_EXT_CORE swaps the core's publish bus for the ext_core port (bench stub).
module top_display_wrapper
    import cpu54_pkg::*;
#(
    parameter int DIV_BITS     = 17,
    parameter bit USE_EXT_CORE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    cpu54_disp_if.slave ext_core,
    output seg_pat_t    atog,
    output digit_sel_t  seg_cs
);
    cpu54_disp_if core_bus ();

    cpu54_core u_core (
        .clk   (clk),
        .reset (reset),
        .disp  (core_bus.master)
    );

    logic              disp_we;
    logic [DATA_W-1:0] disp_data;
    logic [DATA_W-1:0] disp_reg_q = '0;
    logic [DATA_W-1:0] disp_reg_d;

    assign disp_we   = USE_EXT_CORE ? ext_core.disp_we   : core_bus.disp_we;
    assign disp_data = USE_EXT_CORE ? ext_core.disp_data : core_bus.disp_data;

    always_comb begin
        disp_reg_d = disp_reg_q;
        if (disp_we) begin
            disp_reg_d = disp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_reg_q <= '0;
        end else begin
            disp_reg_q <= disp_reg_d;
        end
    end

    seg7_scan #(.DIV_BITS(DIV_BITS)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .value  (disp_reg_q),
        .atog   (atog),
        .seg_cs (seg_cs)
    );
endmodule

// File: tb/tb_top_display_wrapper.sv
// Self-checking bench for top_display_wrapper: scripted scan/write/reset sequences plus
// random publish traffic scored against a cycle-count model of the display.
module tb_top_display_wrapper;

    localparam int DIV_BITS = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] atog;
    logic [7:0] seg_cs;

    cpu54_disp_if bus ();

    top_display_wrapper #(.DIV_BITS(DIV_BITS), .USE_EXT_CORE(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .ext_core (bus),
        .atog     (atog),
        .seg_cs   (seg_cs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flag(input string name, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s: got %b expected 1 (atog=%02h seg_cs=%02h) at %0t",
                     name, ok, atog, seg_cs, $time);
        end
    endtask

    // Segment patterns for hex digits 0..F, active-low, dp off.
    logic [7:0] hex_tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Model: outputs after an edge show the digit selected before it, where the digit is
    // the number of edges since reset divided by 2^DIV_BITS, modulo 8.
    int unsigned m_edges = 0;
    logic [31:0] m_disp  = '0;
    logic [7:0]  m_cs    = 8'hFE;
    logic [7:0]  m_atog  = 8'h03;
    bit          mon_on  = 1'b1;

    always @(posedge clk) begin
        int unsigned digit;
        if (reset) begin
            m_cs    = 8'hFE;
            m_atog  = 8'h03;
            m_edges = 0;
            m_disp  = '0;
        end else begin
            digit   = (m_edges / (1 << DIV_BITS)) % 8;
            m_cs    = ~(8'd1 << digit);
            m_atog  = hex_tbl[(m_disp >> (4 * digit)) & 32'hF];
            m_edges = m_edges + 1;
            if (bus.disp_we) m_disp = bus.disp_data;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check_flag("no_x", !$isunknown({atog, seg_cs}));
            check_flag("cs_onehot", $countones(~seg_cs) == 1);
            check("cs_model", seg_cs, m_cs);
            check("atog_model", atog, m_atog);
        end
    end

    typedef struct {
        int         edge_no;
        logic [7:0] cs;
        logic [7:0] atog;
    } vec_t;

    vec_t tbl [8];
    int   cur;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench on the negedge following the reset edge, with reset released.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.disp_we   = 1'b0;
        bus.disp_data = '0;

        // Digits of 89ABCDEF, each sampled mid-slot after it was written at edge 1.
        tbl[0] = '{2,  8'hFE, 8'h71};
        tbl[1] = '{6,  8'hFD, 8'h61};
        tbl[2] = '{10, 8'hFB, 8'h85};
        tbl[3] = '{14, 8'hF7, 8'h63};
        tbl[4] = '{18, 8'hEF, 8'hC1};
        tbl[5] = '{22, 8'hDF, 8'h11};
        tbl[6] = '{26, 8'hBF, 8'h09};
        tbl[7] = '{30, 8'h7F, 8'h01};

        // Power-up with reset never asserted, random publishes.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.disp_we   = ($urandom_range(0, 7) == 0);
            bus.disp_data = $urandom;
        end
        @(negedge clk);
        bus.disp_we = 1'b0;

        // Reset pulse, first digit advance.
        pulse_reset();
        check("rst_cs", seg_cs, 8'hFE);
        check("rst_atog", atog, 8'h03);
        step(4);
        check("rst_e4_cs", seg_cs, 8'hFE);
        step(1);
        check("rst_e5_cs", seg_cs, 8'hFD);
        check("rst_e5_atog", atog, 8'h03);

        // Full refresh of 89ABCDEF.
        pulse_reset();
        bus.disp_we   = 1'b1;
        bus.disp_data = 32'h89ABCDEF;
        step(1);
        bus.disp_we = 1'b0;
        check("wr_edge_atog", atog, 8'h03);
        cur = 1;
        foreach (tbl[k]) begin
            step(tbl[k].edge_no - cur);
            cur = tbl[k].edge_no;
            check($sformatf("scan_cs_d%0d", k), seg_cs, tbl[k].cs);
            check($sformatf("scan_atog_d%0d", k), atog, tbl[k].atog);
        end

        // Write while digit 3 is selected.
        step(45 - cur);
        check("d3_old_atog", atog, 8'h63);
        bus.disp_we   = 1'b1;
        bus.disp_data = 32'h01234567;
        step(1);
        bus.disp_we = 1'b0;
        check("d3_wr_edge_atog", atog, 8'h63);
        step(1);
        check("d3_new_cs", seg_cs, 8'hF7);
        check("d3_new_atog", atog, 8'h99);
        step(15);
        check("d7_cs", seg_cs, 8'h7F);
        check("d7_atog", atog, 8'h03);

        // Back-to-back writes: last one wins.
        pulse_reset();
        bus.disp_we   = 1'b1;
        bus.disp_data = 32'h1;
        step(1);
        bus.disp_data = 32'h2;
        step(1);
        bus.disp_we = 1'b0;
        check("b2b_e2_atog", atog, 8'h9F);
        step(1);
        check("b2b_e3_atog", atog, 8'h25);
        step(1);
        check("b2b_e4_atog", atog, 8'h25);
        step(2);
        check("b2b_d1_atog", atog, 8'h03);
        step(28);
        check("b2b_wrap_cs", seg_cs, 8'hFE);
        check("b2b_wrap_atog", atog, 8'h25);

        // Reset while digit 5 is selected.
        step(53 - 34);
        check("pre_rst_cs", seg_cs, 8'hDF);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_cs", seg_cs, 8'hFE);
        check("mid_rst_atog", atog, 8'h03);
        step(1);
        check("mid_rst_disp_cleared", atog, 8'h03);
        step(4);
        check("mid_rst_e5_cs", seg_cs, 8'hFD);

        // More random traffic including occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.disp_we   = ($urandom_range(0, 3) == 0);
            bus.disp_data = $urandom;
            reset         = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        bus.disp_we = 1'b0;
        reset       = 1'b0;
        step(2);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
